// File: rtl/serial_add_if.sv
// serial_add_if: start/busy/done handshake and operand/result bus of the bit-serial adder.
interface serial_add_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, cin, a, b, input busy, done, sum, cout, ovf);
    modport slave  (input start, sub, cin, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract controller, one full adder time-shared LSB first.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    serial_add_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             co;
    logic             last;

    assign s    = sh_a[0] ^ sh_b[0] ^ carry;
    assign co   = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    assign last = cnt == CW'(WIDTH - 1);

    // On the last bit, carry still holds the carry into the MSB, so ovf = carry ^ co.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh_a     <= '0;
            sh_b     <= '0;
            res      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sum  <= '0;
            bus.cout <= 1'b0;
            bus.ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    sh_a     <= bus.a;
                    sh_b     <= bus.sub ? ~bus.b : bus.b;
                    carry    <= bus.sub | bus.cin;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                    state    <= RUN;
                end
                RUN: begin
                    res   <= {s, res[WIDTH-1:1]};
                    carry <= co;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    if (last) begin
                        bus.sum  <= {s, res[WIDTH-1:1]};
                        bus.cout <= co;
                        bus.ovf  <= carry ^ co;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
